// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between a byte FIFO (master) and the UART transmitter (slave).
// The slave samples q while q_ready is high and pops the head with a one-cycle strobe.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] q;
  logic             q_ready;
  logic             q_out_strobe;

  modport master (
    output q,
    output q_ready,
    input  q_out_strobe
  );

  modport slave (
    input  q,
    input  q_ready,
    output q_out_strobe
  );

endinterface

// File: rtl/fifo_uart_tx.sv
// Serial transmit stage that pops words from a FIFO and sends each one LSB-first
// as start bit, data bits, optional parity bit and stop bit on the tx line.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_uart_tx_if.slave   fifo,
  input  logic            enable,
  output logic            tx,
  output logic            busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Any PARITY value other than 1 (even) or 2 (odd) sends no parity bit.
  localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state,   state_d;
  logic [WIDTH-1:0] shift,   shift_d;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic             par_bit, par_bit_d;
  logic             tx_d;
  logic             busy_d;
  logic             strobe,  strobe_d;
  logic             load;
  logic             bit_done;

  assign fifo.q_out_strobe = strobe;
  assign bit_done          = (clk_cnt == CNT_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d   = state;
    shift_d   = shift;
    clk_cnt_d = clk_cnt;
    bit_cnt_d = bit_cnt;
    par_bit_d = par_bit;
    tx_d      = tx;
    busy_d    = busy;
    strobe_d  = 1'b0;
    load      = 1'b0;

    if (state != S_IDLE) begin
      clk_cnt_d = bit_done ? '0 : clk_cnt + 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        load = enable && fifo.q_ready;
      end

      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          tx_d      = shift[0];
          shift_d   = shift >> 1;
          bit_cnt_d = '0;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          if (bit_cnt != BIT_LAST) begin
            tx_d      = shift[0];
            shift_d   = shift >> 1;
            bit_cnt_d = bit_cnt + 1'b1;
          end else if (PAR_EN) begin
            state_d = S_PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_done) begin
          // A waiting word chains straight into the next start bit with no idle gap.
          load = enable && fifo.q_ready;
          if (!load) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d   = S_START;
      shift_d   = fifo.q;
      par_bit_d = (PARITY == 2) ? ~^fifo.q : ^fifo.q;
      strobe_d  = 1'b1;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = '0;
      clk_cnt_d = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: reset is asynchronous and abandons any frame in flight; the popped word is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shift   <= '0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      clk_cnt <= clk_cnt_d;
      bit_cnt <= bit_cnt_d;
      par_bit <= par_bit_d;
      tx      <= tx_d;
      busy    <= busy_d;
      strobe  <= strobe_d;
    end
  end

endmodule
